// File: rtl/instr_prefetch_pkg.sv
// Shared types and defaults for the instruction prefetcher.
// Used by the prefetch control, its queue and its bus interface.
package instr_prefetch_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int IW_DEF    = 9;
  localparam int DEPTH_DEF = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } pf_state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Bus bundle of the prefetcher: ROM read port,
// instruction handshake and branch/halt controls.
interface instr_prefetch_if
  import instr_prefetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int IW   = IW_DEF
) ();

  logic [PC_W-1:0] rom_addr_o;
  logic            rom_rd_o;
  logic [IW-1:0]   rom_data_i;
  logic            instr_valid_o;
  logic [IW-1:0]   instr_o;
  logic [PC_W-1:0] instr_pc_o;
  logic            instr_ready_i;
  logic            branch_i;
  logic [PC_W-1:0] branch_target_i;
  logic            halt_i;
  logic            halted_o;

  modport master (
    output rom_addr_o,
    output rom_rd_o,
    input  rom_data_i,
    output instr_valid_o,
    output instr_o,
    output instr_pc_o,
    input  instr_ready_i,
    input  branch_i,
    input  branch_target_i,
    input  halt_i,
    output halted_o
  );

  modport slave (
    input  rom_addr_o,
    input  rom_rd_o,
    output rom_data_i,
    input  instr_valid_o,
    input  instr_o,
    input  instr_pc_o,
    output instr_ready_i,
    output branch_i,
    output branch_target_i,
    output halt_i,
    input  halted_o
  );

endinterface

// File: rtl/instr_prefetch_fifo.sv
// Instruction queue: DEPTH entries of {pc, instr}
// with push/pop, flush and an occupancy count.
module instr_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = PC_W_DEF + IW_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i)
      mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: credit-based ROM fetch into a
// small queue, with branch flush/redirect and halt.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PC_W  = PC_W_DEF,
  parameter int IW    = IW_DEF
) (
  input logic               CLK,
  input logic               start,
  instr_prefetch_if.master  bus
);

  localparam int CW = cnt_w(DEPTH);
  localparam int EW = PC_W + IW;

  pf_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic            pend_q, pend_d;

  logic            issue;
  logic            push;
  logic            pop;
  logic            flush;
  logic            credit_ok;
  logic            valid;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head;

  // In-flight read holds a slot so a return never hits a full queue
  assign credit_ok =
    (count + CW'(pend_q)) < CW'(DEPTH);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pend_d    = 1'b0;
    issue     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    valid     = 1'b0;
    if (!start) begin
      unique case (state_q)
        RUN: begin
          valid = (count != '0);
          issue = !bus.branch_i && credit_ok;
          push  = pend_q && !bus.branch_i;
          pop   = valid && bus.instr_ready_i
                  && !bus.branch_i;
          if (bus.halt_i) begin
            state_d = HALT;
          end else if (bus.branch_i) begin
            flush = 1'b1;
            pc_d  = bus.branch_target_i;
          end
          if (issue) begin
            pc_d      = pc_q + PC_W'(1);
            pend_pc_d = pc_q;
          end
          pend_d = issue;
        end
        HALT: begin
          state_d = HALT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      state_q   <= RUN;
      pc_q      <= '0;
      pend_pc_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pend_q    <= pend_d;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (start),
    .flush_i (flush),
    .push_i  (push),
    .data_i  ({pend_pc_q, bus.rom_data_i}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  assign bus.rom_rd_o      = issue;
  assign bus.rom_addr_o    = pc_q;
  assign bus.instr_valid_o = valid;
  assign bus.instr_pc_o    = head[EW-1 -: PC_W];
  assign bus.instr_o       = head[IW-1:0];
  assign bus.halted_o      = !start && (state_q == HALT);

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch with a ROM model
// and a scoreboard of expected {pc, instr} entries.
module tb_instr_prefetch;
  import instr_prefetch_pkg::*;

  localparam int PC_W  = 8;
  localparam int IW    = 9;
  localparam int DEPTH = 4;
  localparam int EW    = PC_W + IW;

  logic CLK   = 1'b0;
  logic start = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [PC_W-1:0] exp_pc = '0;
  logic [EW-1:0]   sbq [$];

  instr_prefetch_if #(.PC_W(PC_W), .IW(IW)) bus ();

  instr_prefetch #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W),
    .IW    (IW)
  ) dut (
    .CLK   (CLK),
    .start (start),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // ROM: data = addr + 0x100, one cycle after the strobe
  always @(posedge CLK) begin
    if (bus.rom_rd_o)
      bus.rom_data_i <= IW'(bus.rom_addr_o) + IW'(9'h100);
    else
      bus.rom_data_i <= IW'(9'h0FF);
  end

  // Scoreboard: expected entries queued at issue, checked at pop
  always @(negedge CLK) begin
    logic [EW-1:0] e;
    if (start) begin
      sbq.delete();
      exp_pc = '0;
    end else begin
      if (bus.instr_valid_o && bus.instr_ready_i
          && !bus.branch_i) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_pop: got pc=%h instr=%h, none expected",
                   bus.instr_pc_o, bus.instr_o);
        end else begin
          e = sbq.pop_front();
          if ({bus.instr_pc_o, bus.instr_o} !== e) begin
            errors++;
            $display("FAIL sb_data: got pc=%h instr=%h, want pc=%h instr=%h",
                     bus.instr_pc_o, bus.instr_o,
                     e[EW-1 -: PC_W], e[IW-1:0]);
          end
        end
      end
      if (bus.rom_rd_o) begin
        checks++;
        if (bus.rom_addr_o !== exp_pc) begin
          errors++;
          $display("FAIL sb_addr: got %h want %h",
                   bus.rom_addr_o, exp_pc);
        end
        sbq.push_back({exp_pc,
                       IW'(exp_pc) + IW'(9'h100)});
        exp_pc = exp_pc + PC_W'(1);
      end
      if (bus.halt_i) begin
        sbq.delete();
      end else if (bus.branch_i) begin
        sbq.delete();
        exp_pc = bus.branch_target_i;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b1;
    bus.branch_i = 1'b0;
    bus.halt_i = 1'b0;
    step();
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    bus.instr_ready_i = 1'b1;
    start = 1'b1;
    step();
    step();
    @(negedge CLK);
    checks++;
    if (bus.rom_rd_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd: got %b want 0", bus.rom_rd_o);
    end
    checks++;
    if (bus.instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b want 0",
               bus.instr_valid_o);
    end
    checks++;
    if (bus.halted_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_halted: got %b want 0",
               bus.halted_o);
    end
    step();
    start = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.rom_rd_o !== 1'b1 || bus.rom_addr_o !== 8'h00) begin
      errors++;
      $display("FAIL first_issue: got rd=%b addr=%h want 1/00",
               bus.rom_rd_o, bus.rom_addr_o);
    end
    step();
    @(negedge CLK);
    checks++;
    if (bus.rom_rd_o !== 1'b1 || bus.rom_addr_o !== 8'h01) begin
      errors++;
      $display("FAIL second_issue: got rd=%b addr=%h want 1/01",
               bus.rom_rd_o, bus.rom_addr_o);
    end
    step();
    @(negedge CLK);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 8'h00
        || bus.instr_o !== 9'h100) begin
      errors++;
      $display("FAIL first_instr: got v=%b pc=%h i=%h want 1/00/100",
               bus.instr_valid_o, bus.instr_pc_o, bus.instr_o);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 16; i++) begin
      step();
      @(negedge CLK);
      checks++;
      if (bus.instr_valid_o !== 1'b1 || bus.rom_rd_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b rd=%b want 1/1",
                 i, bus.instr_valid_o, bus.rom_rd_o);
      end
    end
  endtask

  task automatic test_backpressure();
    int  n;
    bit  found;
    n = 0;
    found = 1'b0;
    bus.instr_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (bus.rom_rd_o) n++;
      step();
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL bp_reads: got %0d want %0d", n, DEPTH);
    end
    @(negedge CLK);
    checks++;
    if (bus.rom_rd_o !== 1'b0 || bus.instr_valid_o !== 1'b1
        || bus.instr_pc_o !== 8'h00) begin
      errors++;
      $display("FAIL bp_hold: got rd=%b v=%b pc=%h want 0/1/00",
               bus.rom_rd_o, bus.instr_valid_o, bus.instr_pc_o);
    end
    step();
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (bus.rom_rd_o) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found || bus.rom_addr_o !== 8'h04) begin
      errors++;
      $display("FAIL bp_resume: got found=%b addr=%h want 1/04",
               found, bus.rom_addr_o);
    end
  endtask

  task automatic test_branch();
    bit found;
    found = 1'b0;
    bus.instr_ready_i = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus.rom_rd_o && bus.rom_addr_o == 8'h06) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL br_timeout: addr 06 never issued, want issue");
    end
    step();
    bus.instr_ready_i = 1'b0;
    step();
    step();
    bus.branch_i = 1'b1;
    bus.branch_target_i = 8'h80;
    @(negedge CLK);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 8'h05
        || bus.rom_rd_o !== 1'b0) begin
      errors++;
      $display("FAIL br_pre: got v=%b pc=%h rd=%b want 1/05/0",
               bus.instr_valid_o, bus.instr_pc_o, bus.rom_rd_o);
    end
    step();
    bus.branch_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.rom_rd_o !== 1'b1 || bus.rom_addr_o !== 8'h80
        || bus.instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL br_issue: got rd=%b addr=%h v=%b want 1/80/0",
               bus.rom_rd_o, bus.rom_addr_o, bus.instr_valid_o);
    end
    step();
    @(negedge CLK);
    checks++;
    if (bus.instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL br_gap: got v=%b want 0", bus.instr_valid_o);
    end
    step();
    @(negedge CLK);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 8'h80
        || bus.instr_o !== 9'h180) begin
      errors++;
      $display("FAIL br_target: got v=%b pc=%h i=%h want 1/80/180",
               bus.instr_valid_o, bus.instr_pc_o, bus.instr_o);
    end
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] exp_a [4];
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    bus.instr_ready_i = 1'b1;
    step();
    bus.branch_i = 1'b1;
    bus.branch_target_i = 8'hFE;
    step();
    bus.branch_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      checks++;
      if (bus.rom_rd_o !== 1'b1 || bus.rom_addr_o !== exp_a[k]) begin
        errors++;
        $display("FAIL wrap_%0d: got rd=%b addr=%h want 1/%h",
                 k, bus.rom_rd_o, bus.rom_addr_o, exp_a[k]);
      end
      step();
    end
  endtask

  task automatic test_halt_branch();
    bus.instr_ready_i = 1'b1;
    step();
    bus.halt_i = 1'b1;
    bus.branch_i = 1'b1;
    bus.branch_target_i = 8'h40;
    @(negedge CLK);
    checks++;
    if (bus.rom_rd_o !== 1'b0) begin
      errors++;
      $display("FAIL hb_rd: got %b want 0", bus.rom_rd_o);
    end
    step();
    bus.halt_i = 1'b0;
    bus.branch_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.halted_o !== 1'b1 || bus.rom_rd_o !== 1'b0
          || bus.instr_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL halt_%0d: got h=%b rd=%b v=%b want 1/0/0",
                 i, bus.halted_o, bus.rom_rd_o, bus.instr_valid_o);
      end
      step();
    end
    start = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.halted_o !== 1'b0) begin
      errors++;
      $display("FAIL halt_rst: got %b want 0", bus.halted_o);
    end
    step();
    start = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.rom_rd_o !== 1'b1 || bus.rom_addr_o !== 8'h00
        || bus.halted_o !== 1'b0) begin
      errors++;
      $display("FAIL halt_exit: got rd=%b addr=%h h=%b want 1/00/0",
               bus.rom_rd_o, bus.rom_addr_o, bus.halted_o);
    end
  endtask

  task automatic test_start_mid();
    bus.instr_ready_i = 1'b0;
    do_reset();
    step();
    step();
    @(negedge CLK);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 8'h00) begin
      errors++;
      $display("FAIL sm_pre: got v=%b pc=%h want 1/00",
               bus.instr_valid_o, bus.instr_pc_o);
    end
    step();
    start = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.instr_valid_o !== 1'b0 || bus.rom_rd_o !== 1'b0) begin
      errors++;
      $display("FAIL sm_during: got v=%b rd=%b want 0/0",
               bus.instr_valid_o, bus.rom_rd_o);
    end
    step();
    start = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.instr_valid_o !== 1'b0 || bus.rom_rd_o !== 1'b1
        || bus.rom_addr_o !== 8'h00) begin
      errors++;
      $display("FAIL sm_after: got v=%b rd=%b addr=%h want 0/1/00",
               bus.instr_valid_o, bus.rom_rd_o, bus.rom_addr_o);
    end
    step();
    @(negedge CLK);
    checks++;
    if (bus.instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL sm_stale: got v=%b want 0", bus.instr_valid_o);
    end
    step();
    @(negedge CLK);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 8'h00
        || bus.instr_o !== 9'h100) begin
      errors++;
      $display("FAIL sm_first: got v=%b pc=%h i=%h want 1/00/100",
               bus.instr_valid_o, bus.instr_pc_o, bus.instr_o);
    end
  endtask

  initial begin
    bus.instr_ready_i = 1'b1;
    bus.branch_i = 1'b0;
    bus.branch_target_i = '0;
    bus.halt_i = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_wrap();
    test_halt_branch();
    test_start_mid();
    step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
